// File: rtl/vid_rd_sched.sv
// Frame-read scheduler: picks the newest finished frame buffer on each VTC sync,
// flushes the line FIFO and streams the frame out of DDR as FIFO-gated bursts.
module vid_rd_sched #(
    parameter int H_ActiveSize = 1920,
    parameter int V_ActiveSize = 1080,
    parameter int BEAT_PIX     = 8,
    parameter int BEAT_BYTES   = 16,
    parameter int BURST_BEATS  = 16,
    parameter int FIFO_DEPTH   = 512,
    parameter int FLUSH_CYCLES = 4,
    parameter int ADDR_W       = 28,
    parameter logic [ADDR_W-1:0] FRAME_BASE   = 28'h0000000,
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = 28'h0800000
) (
    input  logic              I_sch_clk,
    input  logic              I_sch_rst,
    input  logic              I_vtc_vs,
    input  logic              I_wr_frame_done,
    input  logic [1:0]        I_wr_frame_idx,
    input  logic [9:0]        I_fifo_wcnt,
    output logic              O_rd_req,
    input  logic              I_rd_ack,
    output logic [ADDR_W-1:0] O_rd_addr,
    output logic [7:0]        O_rd_len,
    input  logic              I_rd_done,
    output logic              O_fifo_flush,
    output logic [1:0]        O_rd_frame_idx,
    output logic              O_frame_late,
    output logic              O_busy
);

    localparam int FRAME_BEATS = H_ActiveSize * V_ActiveSize / BEAT_PIX;
    localparam int BCNT_W      = $clog2(FRAME_BEATS + 1);
    localparam int FCNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_CHECK, S_REQ, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic                vs_q;
    logic [FCNT_W-1:0]   flushCnt_q, flushCnt_d;
    logic [BCNT_W-1:0]   beatCnt_q, beatCnt_d;
    logic [1:0]          latestIdx_q, latestIdx_d;
    logic                newFlag_q, newFlag_d;
    logic [1:0]          frameIdx_q, frameIdx_d;
    logic                restart_q, restart_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic                flush_q, flush_d;
    logic                late_q, late_d;
    logic                busy_q, busy_d;

    logic                syncEvt;
    logic                spaceOk;
    logic [31:0]         remaining;
    logic [31:0]         lenFull;
    logic [63:0]         addrFull;

    assign syncEvt = I_vtc_vs & ~vs_q;
    assign spaceOk = (32'(I_fifo_wcnt) + 32'(len_q)) <= 32'(FIFO_DEPTH);

    always_comb begin
        state_d     = state_q;
        flushCnt_d  = flushCnt_q;
        beatCnt_d   = beatCnt_q;
        latestIdx_d = latestIdx_q;
        newFlag_d   = newFlag_q;
        frameIdx_d  = frameIdx_q;
        restart_d   = restart_q;
        late_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (syncEvt) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                beatCnt_d = '0;
                if (flushCnt_q == FCNT_W'(FLUSH_CYCLES - 1)) state_d = S_CHECK;
                else flushCnt_d = flushCnt_q + 1'b1;
            end
            S_CHECK: begin
                // A finished frame meeting a sync is simply the next frame, not a late one.
                if (beatCnt_q == BCNT_W'(FRAME_BEATS)) begin
                    state_d = syncEvt ? S_FLUSH : S_IDLE;
                end else if (syncEvt) begin
                    late_d  = 1'b1;
                    state_d = S_FLUSH;
                end else if (spaceOk) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (syncEvt) begin
                    late_d    = 1'b1;
                    restart_d = 1'b1;
                end
                if (I_rd_ack) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (syncEvt) begin
                    late_d    = 1'b1;
                    restart_d = 1'b1;
                end
                if (I_rd_done) begin
                    beatCnt_d = beatCnt_q + BCNT_W'(len_q);
                    state_d   = (restart_q || syncEvt) ? S_FLUSH : S_CHECK;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Buffer switch happens only on FLUSH entry; a same-cycle done pulse lands for the next frame.
        if (state_d == S_FLUSH && state_q != S_FLUSH) begin
            flushCnt_d = '0;
            beatCnt_d  = '0;
            restart_d  = 1'b0;
            if (newFlag_q) begin
                frameIdx_d = latestIdx_q;
                newFlag_d  = 1'b0;
            end
        end
        if (I_wr_frame_done) begin
            latestIdx_d = I_wr_frame_idx;
            newFlag_d   = 1'b1;
        end
    end

    assign remaining = 32'(FRAME_BEATS) - 32'(beatCnt_d);
    assign lenFull   = (remaining > 32'(BURST_BEATS)) ? 32'(BURST_BEATS) : remaining;
    assign addrFull  = 64'(FRAME_BASE) + 64'(frameIdx_d) * 64'(FRAME_STRIDE)
                     + 64'(beatCnt_d) * 64'(BEAT_BYTES);

    // Outputs are registered copies of the next state so they line up with it.
    always_comb begin
        req_d   = (state_d == S_REQ);
        flush_d = (state_d == S_FLUSH);
        busy_d  = (state_d != S_IDLE);
        addr_d  = addr_q;
        len_d   = len_q;
        if (state_d != S_IDLE) begin
            addr_d = addrFull[ADDR_W-1:0];
            len_d  = lenFull[7:0];
        end
    end

    always_ff @(posedge I_sch_clk or posedge I_sch_rst) begin
        if (I_sch_rst) begin
            state_q     <= S_IDLE;
            vs_q        <= 1'b0;
            flushCnt_q  <= '0;
            beatCnt_q   <= '0;
            latestIdx_q <= 2'd0;
            newFlag_q   <= 1'b0;
            frameIdx_q  <= 2'd0;
            restart_q   <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            len_q       <= 8'd0;
            flush_q     <= 1'b0;
            late_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= I_vtc_vs;
            flushCnt_q  <= flushCnt_d;
            beatCnt_q   <= beatCnt_d;
            latestIdx_q <= latestIdx_d;
            newFlag_q   <= newFlag_d;
            frameIdx_q  <= frameIdx_d;
            restart_q   <= restart_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            flush_q     <= flush_d;
            late_q      <= late_d;
            busy_q      <= busy_d;
        end
    end

    assign O_rd_req       = req_q;
    assign O_rd_addr      = addr_q;
    assign O_rd_len       = len_q;
    assign O_fifo_flush   = flush_q;
    assign O_rd_frame_idx = frameIdx_q;
    assign O_frame_late   = late_q;
    assign O_busy         = busy_q;

endmodule
